// File: rtl/npc_defs.sv
// Shared definitions for the NPC pipeline.
//   - branch-class encodings carried on the decode -> execute in_br field
//   - Alu control codes
//   - beat_t: one result beat travelling from execute to memory/writeback
package npc_defs;

  localparam int unsigned NPC_XLEN = 32;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LT   = 3'b011,
    BR_GE   = 3'b100,
    BR_LTU  = 3'b101,
    BR_GEU  = 3'b110,
    BR_JUMP = 3'b111
  } br_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_e;

  typedef struct packed {
    logic [NPC_XLEN-1:0] pc;
    logic [NPC_XLEN-1:0] wdata;
    logic [4:0]          rd;
    logic                wen;
  } beat_t;

endpackage

// File: rtl/Alu.sv
// Combinational ALU.
//   a, b   : operands
//   op     : 000 add, 001 sub, 010 and, 011 or; any other code gives 0
//   result : operation result
//   zf/nf  : result is zero / result sign bit
//   cf     : carry out of add; for sub, 1 means no borrow (a >= b unsigned)
//   of     : signed overflow of add/sub; 0 for logic ops
module Alu
  import npc_defs::*;
(
  input  logic [NPC_XLEN-1:0] a,
  input  logic [NPC_XLEN-1:0] b,
  input  logic [2:0]          op,
  output logic [NPC_XLEN-1:0] result,
  output logic                zf,
  output logic                nf,
  output logic                cf,
  output logic                of
);

  logic [NPC_XLEN:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    cf     = 1'b0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[NPC_XLEN-1:0];
        cf     = sum[NPC_XLEN];
        of     = (a[NPC_XLEN-1] == b[NPC_XLEN-1]) && (result[NPC_XLEN-1] != a[NPC_XLEN-1]);
      end
      ALU_SUB: begin
        // Two's-complement subtract: carry out set means no borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + {{NPC_XLEN{1'b0}}, 1'b1};
        result = sum[NPC_XLEN-1:0];
        cf     = sum[NPC_XLEN];
        of     = (a[NPC_XLEN-1] != b[NPC_XLEN-1]) && (result[NPC_XLEN-1] != a[NPC_XLEN-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign nf = result[NPC_XLEN-1];

endmodule

// File: rtl/br_cond.sv
// Branch condition evaluation from Alu flags of a subtract (a - b).
//   br             : branch class (BR_NONE..BR_JUMP)
//   zf, nf, cf, of : Alu flags
//   taken          : 1 when the branch/jump redirects fetch
module br_cond
  import npc_defs::*;
(
  input  logic [2:0] br,
  input  logic       zf,
  input  logic       nf,
  input  logic       cf,
  input  logic       of,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br)
      BR_EQ:   taken = zf;
      BR_NE:   taken = ~zf;
      BR_LT:   taken = nf ^ of;
      BR_GE:   taken = ~(nf ^ of);
      BR_LTU:  taken = ~cf;        // borrow occurred
      BR_GEU:  taken = cf;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: drives the Alu from the incoming micro-op, builds the
// writeback beat, resolves branches/jumps and pulses a fetch redirect.
// Results leave through a two-entry buffer (output register + skid).
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid / in_ready       : upstream handshake
//   in_pc, in_a, in_b, in_imm : micro-op PC, Alu operands, branch offset
//   in_aluop, in_br           : Alu control, branch class
//   in_rd, in_wen             : destination register, write enable
//   out_valid / out_ready     : downstream handshake
//   out_pc, out_wdata, out_rd, out_wen : result beat
//   redirect_valid, redirect_pc        : one-cycle fetch redirect
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_aluop,
  input  logic [2:0]      in_br,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_wdata,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  import npc_defs::*;

  // ---------------- execute datapath ----------------
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_res;
  logic            zf, nf, cf, of;
  logic            is_cond;
  logic            taken;
  logic [XLEN-1:0] target;
  beat_t           new_beat;

  assign is_cond = (in_br != BR_NONE) && (in_br != BR_JUMP);

  // Conditional branches compare via subtract regardless of decode's aluop.
  always_comb begin
    alu_op = in_aluop;
    if (is_cond) begin
      alu_op = ALU_SUB;
    end
  end

  Alu u_alu (
    .a      (in_a),
    .b      (in_b),
    .op     (alu_op),
    .result (alu_res),
    .zf     (zf),
    .nf     (nf),
    .cf     (cf),
    .of     (of)
  );

  br_cond u_br_cond (
    .br    (in_br),
    .zf    (zf),
    .nf    (nf),
    .cf    (cf),
    .of    (of),
    .taken (taken)
  );

  always_comb begin
    new_beat.pc    = in_pc;
    new_beat.rd    = in_rd;
    new_beat.wdata = alu_res;
    new_beat.wen   = in_wen;
    target         = in_pc + in_imm;
    if (in_br == BR_JUMP) begin
      new_beat.wdata = in_pc + 32'd4;
      target         = {alu_res[XLEN-1:1], 1'b0};
    end else if (is_cond) begin
      new_beat.wdata = '0;
      new_beat.wen   = 1'b0;
    end
  end

  // ---------------- output buffer + redirect ----------------
  beat_t           e0_reg, e0_next;
  beat_t           e1_reg, e1_next;
  logic            e0_valid_reg, e0_valid_next;
  logic            e1_valid_reg, e1_valid_next;
  logic            redirect_valid_reg, redirect_valid_next;
  logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;

  logic accept;
  logic keep;
  logic consume;

  // Ready depends only on registered state. While a redirect is pending the
  // presented beat is wrong-path and is swallowed, so ready is forced high.
  assign in_ready = ~e1_valid_reg | redirect_valid_reg;
  assign accept   = in_valid & in_ready;
  assign keep     = accept & ~redirect_valid_reg;
  assign consume  = e0_valid_reg & out_ready;

  always_comb begin
    e0_next             = e0_reg;
    e1_next             = e1_reg;
    e0_valid_next       = e0_valid_reg;
    e1_valid_next       = e1_valid_reg;
    redirect_valid_next = keep & taken;
    redirect_pc_next    = redirect_pc_reg;

    if (keep && taken) begin
      redirect_pc_next = target;
    end

    if (consume) begin
      if (e1_valid_reg) begin
        // Skid moves forward; a new beat (only possible as a kept beat) queues behind it.
        e0_next       = e1_reg;
        e1_valid_next = keep;
        if (keep) begin
          e1_next = new_beat;
        end
      end else if (keep) begin
        e0_next = new_beat;
      end else begin
        e0_valid_next = 1'b0;
      end
    end else if (!e0_valid_reg) begin
      if (keep) begin
        e0_next       = new_beat;
        e0_valid_next = 1'b1;
      end
    end else if (keep) begin
      // Entry 0 is stalled: park the beat in the skid.
      e1_next       = new_beat;
      e1_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_reg             <= '0;
      e1_reg             <= '0;
      e0_valid_reg       <= 1'b0;
      e1_valid_reg       <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      e0_reg             <= e0_next;
      e1_reg             <= e1_next;
      e0_valid_reg       <= e0_valid_next;
      e1_valid_reg       <= e1_valid_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
    end
  end

  assign out_valid      = e0_valid_reg;
  assign out_pc         = e0_reg.pc;
  assign out_wdata      = e0_reg.wdata;
  assign out_rd         = e0_reg.rd;
  assign out_wen        = e0_reg.wen;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model (queue of expected beats
// plus the expected redirect).
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_a, in_b, in_imm;
  logic [2:0]  in_aluop, in_br;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_wdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ex_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_imm         (in_imm),
    .in_aluop       (in_aluop),
    .in_br          (in_br),
    .in_rd          (in_rd),
    .in_wen         (in_wen),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_wdata      (out_wdata),
    .out_rd         (out_rd),
    .out_wen        (out_wen),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_redirect;
  logic [31:0] exp_rpc;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: what the micro-op means architecturally.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
    case (br)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return $signed(a) < $signed(b);
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a < b;
      3'd6:    return a >= b;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_wdata", out_wdata, exp_q[0].wdata);
      chk("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
      chk("out_wen", {31'd0, out_wen}, {31'd0, exp_q[0].wen});
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2) || exp_redirect});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_redirect});
    if (exp_redirect) chk("redirect_pc", redirect_pc, exp_rpc);
  endtask

  // One clock cycle: check current outputs, drive a micro-op, advance model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic [2:0] op,
                      input logic [2:0] br, input logic [4:0] rd, input logic wen,
                      input logic ordy, output logic accepted);
    exp_t        nb;
    logic        consume, acc, kp, tk;
    logic [31:0] tgt;
    check_outputs();
    in_valid = v; in_pc = pc; in_a = a; in_b = b; in_imm = imm;
    in_aluop = op; in_br = br; in_rd = rd; in_wen = wen; out_ready = ordy;

    nb.pc = pc; nb.rd = rd;
    tk = ref_cond(br, a, b);
    if (br == 3'd0) begin
      nb.wdata = ref_alu(op, a, b); nb.wen = wen; tgt = 32'd0;
    end else if (br == 3'd7) begin
      nb.wdata = pc + 32'd4; nb.wen = wen; tgt = ref_alu(op, a, b) & 32'hFFFF_FFFE;
    end else begin
      nb.wdata = 32'd0; nb.wen = 1'b0; tgt = pc + imm;
    end
    consume  = (exp_q.size() > 0) && ordy;
    acc      = v && ((exp_q.size() < 2) || exp_redirect);
    kp       = acc && !exp_redirect;
    accepted = acc;
    if (consume) void'(exp_q.pop_front());
    if (kp) exp_q.push_back(nb);
    exp_redirect = kp && tk;
    if (exp_redirect) exp_rpc = tgt;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b1; in_br = 3'd7; in_a = 32'h1234_5679; in_b = 32'd0;
    in_pc = 32'h40; in_rd = 5'd2; in_wen = 1'b1; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    exp_redirect = 1'b0;
    exp_rpc = 32'd0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
  endtask

  initial begin
    logic        acc;
    int          n_acc;
    int          cyc;
    logic [31:0] ra, rb;
    errors = 0; checks = 0;
    exp_redirect = 1'b0; exp_rpc = 32'd0;
    rst = 1'b1; in_valid = 1'b0; in_pc = 0; in_a = 0; in_b = 0; in_imm = 0;
    in_aluop = 0; in_br = 0; in_rd = 0; in_wen = 0; out_ready = 1'b1;
    @(negedge clk);
    do_reset(2);

    // ADD with signed overflow into the sign bit.
    step(1, 32'h100, 32'h7FFF_FFFF, 32'd1, 32'd0, 3'd0, 3'd0, 5'd5, 1, 1, acc);
    chk("add_wdata", out_wdata, 32'h8000_0000);
    chk("add_rd", {27'd0, out_rd}, 32'd5);
    chk("add_redirect", {31'd0, redirect_valid}, 32'd0);

    // LTU taken (aluop deliberately not sub), then a wrong-path beat.
    step(1, 32'h8000_0010, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 3'd2, 3'd5, 5'd3, 1, 1, acc);
    chk("ltu_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("ltu_redirect_pc", redirect_pc, 32'h8000_0000);
    chk("ltu_wen", {31'd0, out_wen}, 32'd0);
    step(1, 32'h8000_0014, 32'd3, 32'd4, 32'd0, 3'd0, 3'd0, 5'd9, 1, 1, acc);
    chk("drop_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_redirect", {31'd0, redirect_valid}, 32'd0);

    // LT with the same operands: not taken.
    step(1, 32'h8000_0010, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 3'd0, 3'd3, 5'd3, 1, 1, acc);
    chk("lt_redirect", {31'd0, redirect_valid}, 32'd0);

    // JUMP.
    step(1, 32'h8000_0020, 32'h8000_0101, 32'd4, 32'd0, 3'd0, 3'd7, 5'd1, 1, 1, acc);
    chk("jump_redirect_pc", redirect_pc, 32'h8000_0104);
    chk("jump_wdata", out_wdata, 32'h8000_0024);
    step(0, 0, 0, 0, 0, 3'd0, 3'd0, 5'd0, 0, 1, acc);
    chk("jump_pulse_one_cycle", {31'd0, redirect_valid}, 32'd0);

    // Backpressure: 6 ADD beats, out_ready low in cycles 2..4.
    n_acc = 0;
    cyc = 1;
    while (n_acc < 6 && cyc < 40) begin
      step(1, 32'h200 + 32'(n_acc * 4), 32'(n_acc * 16), 32'd1, 32'd0, 3'd0, 3'd0,
           5'(10 + n_acc), 1, !(cyc >= 2 && cyc <= 4), acc);
      if (acc) n_acc++;
      cyc++;
    end
    chk("bp_accepted", n_acc, 6);
    repeat (4) step(0, 0, 0, 0, 0, 3'd0, 3'd0, 5'd0, 0, 1, acc);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Mid-run reset with both entries full and a taken branch just accepted.
    step(1, 32'h300, 32'd5, 32'd6, 32'd0, 3'd0, 3'd0, 5'd7, 1, 0, acc);
    step(1, 32'h304, 32'd9, 32'd9, 32'h40, 3'd0, 3'd1, 5'd0, 0, 0, acc);
    chk("pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
    do_reset(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, ra, rb, $urandom,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom),
           1'($urandom), $urandom_range(0, 9) < 6, acc);
    end
    repeat (4) step(0, 0, 0, 0, 0, 3'd0, 3'd0, 5'd0, 0, 1, acc);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the NPC pipeline, between decode and memory/writeback. Accepts one decoded micro-op per cycle over a valid/ready handshake and drives the `Alu` block with its operands and control. It consumes the ALU result and flags to produce writeback data, resolve branches and jumps, and issue a one-cycle redirect. Output passes through a 2-entry skid buffer, so full throughput holds under downstream stalls.

## Interface
- `XLEN`, 32: datapath width; 32 is the only legal value (matches `Alu`).
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `in_pc` in 32: PC of the micro-op.
- `in_a`, `in_b` in 32: ALU operands, already selected by decode.
- `in_imm` in 32: branch offset.
- `in_aluop` in 3: `Alu` control (000 add, 001 sub, 010 and, 011 or; others give result 0).
- `in_br` in 3: 000 NONE, 001 EQ, 010 NE, 011 LT, 100 GE, 101 LTU, 110 GEU, 111 JUMP.
- `in_rd` in 5, `in_wen` in 1: destination register and write enable.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `out_pc` out 32, `out_wdata` out 32, `out_rd` out 5, `out_wen` out 1: result beat.
- `redirect_valid` out 1, `redirect_pc` out 32: fetch redirect.

## Operation
- The ALU is driven combinationally from the `in_*` operand and control ports. For conditional branches (`in_br` 001–110), the stage forces ALU control to 001 (sub), regardless of `in_aluop`.
- Conditions are evaluated from the ALU flags:
  - EQ=zf, NE=~zf.
  - LT=nf^of, GE=~(nf^of).
  - LTU=~cf, GEU=cf. cf=1 on sub means no borrow.
- Beat contents by `in_br`:
  - NONE: wdata = ALU result, wen = in_wen.
  - Conditional: wdata = 0, wen = 0. Target = in_pc + in_imm (mod 2^32). Taken = condition true.
  - JUMP: always taken. Target = ALU result & ~1. wdata = in_pc + 4, wen = in_wen.
- Redirect: on the clock edge accepting a taken beat, `redirect_valid` is set to 1 and `redirect_pc` to the target, for exactly one cycle. This is independent of `out_ready`.
- Wrong-path drop: in the cycle `redirect_valid` = 1, `in_ready` = 1 and any presented beat is accepted and discarded. It produces no output and no redirect.
- The branch/jump beat itself always proceeds downstream (for retire/trace).
- Misaligned targets are not checked.

## Timing
- Latency: a beat accepted at edge N has `out_valid` = 1 from cycle N+1.
- Throughput: 1 beat/cycle when `out_ready` = 1.
- Buffer: output register (entry 0) plus skid register (entry 1). `in_ready` = ~skid_valid, registered, with no combinational path from `out_ready`.
- Backpressure: on `out_valid` & ~`out_ready`, entry 0 holds. A beat accepted in that cycle goes to the skid. `in_ready` drops the following cycle.
- Drain: when entry 0 is consumed, the skid moves into entry 0 at the same edge, and any simultaneous new beat goes to entry 0 or the skid while preserving order. There is no loss, duplication or reordering.
- Simultaneous accept and consume with an empty skid: the new beat replaces entry 0.
- Reset: all valids, `redirect_valid`, `redirect_pc`, `out_*` data and the skid are 0. `in_ready` = 1 after reset. A beat presented while `rst` = 1 is ignored.
- Reset mid-operation clears both entries and any pending redirect at the next edge.

## Structure
- Shared package/header `npc_defs`: `in_br` encodings (BR_NONE..BR_JUMP) and ALU op codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR).
- Instantiates `Alu` unchanged.
- One new combinational sub-module, `br_cond`: inputs `in_br` plus zf/nf/cf/of, output taken.
- Skid buffer is inline (about 60 lines); total RTL about 200 lines.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `redirect_valid` = 0, no beat emitted. `in_ready` = 1 afterwards.
- ADD: a = 0x7FFFFFFF, b = 1, aluop 000, NONE, rd 5, wen 1 → next cycle `out_wdata` = 0x80000000, `out_rd` = 5, `out_wen` = 1, no redirect.
- Unsigned vs signed branch, with a = 1, b = 0xFFFFFFFF, pc = 0x80000010, imm = 0xFFFFFFF0:
  - LTU → taken; `redirect_pc` = 0x80000000 pulsed for 1 cycle; `out_wen` = 0. A beat presented in the redirect cycle is dropped.
  - LT → not taken; no redirect.
- JUMP: a = 0x80000101, b = 4, pc = 0x80000020, rd 1 → `redirect_pc` = 0x80000104, `out_wdata` = 0x80000024.
- Backpressure: 6 consecutive ADD beats with `out_ready` = 0 for cycles 2–4 → `in_ready` low while the skid is full. All 6 results emerge in order, with none lost or duplicated.
- Mid-run reset: both entries full and a taken branch just accepted, assert `rst` → next cycle all valids 0 and `redirect_valid` = 0.
